// File: rtl/sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : sram_responder
// Brief    : On-chip word array answering SLC-3 SRAM bus cycles, with read
//            latency, byte-lane writes and a side preload port.
// Revision : 1.0 - initial release
// ============================================================================
module sram_responder #(
    parameter int ADDR_W   = 10,
    parameter int READ_LAT = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              CE,
    input  logic              UB,
    input  logic              LB,
    input  logic              OE,
    input  logic              WE,
    input  logic [19:0]       ADDR,
    inout  wire  [15:0]       Data,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [15:0]       load_data,
    output logic              oor_err
);

    localparam int c_DEPTH = 1 << ADDR_W;
    localparam int c_CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_LAT_M1 = c_CNT_W'(READ_LAT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_DRIVE = 2'd2
    } state_t;

    state_t              state_q;
    logic [c_CNT_W-1:0]  cnt_q;
    logic [19:0]         addr_q;
    logic                addr_oor_q;
    logic [15:0]         rdata_q;
    logic                oor_q;
    logic [15:0]         mem_q [0:c_DEPTH-1];

    logic        w_rd_req;
    logic        w_wr_req;
    logic        w_addr_oor;
    logic        w_capture;
    logic [15:0] w_live_word;
    logic [15:0] w_cap_word;

    assign w_rd_req = !CE && WE && !OE;
    assign w_wr_req = !CE && !WE;

    if (ADDR_W < 20) begin : g_oor_chk
        assign w_addr_oor = |ADDR[19:ADDR_W];
    end else begin : g_no_oor
        assign w_addr_oor = 1'b0;
    end

    assign w_live_word = w_addr_oor ? 16'h0000 : mem_q[ADDR[ADDR_W-1:0]];
    assign w_cap_word  = addr_oor_q ? 16'h0000 : mem_q[addr_q[ADDR_W-1:0]];

    // A new read starts from IDLE, or restarts when the address moves mid-read.
    assign w_capture = w_rd_req && ((state_q == IDLE) || (ADDR != addr_q));

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            addr_oor_q <= 1'b0;
            rdata_q    <= '0;
            oor_q      <= 1'b0;
        end else begin
            if ((w_rd_req || w_wr_req) && w_addr_oor)
                oor_q <= 1'b1;
            if (!w_rd_req) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else if (w_capture) begin
                addr_q     <= ADDR;
                addr_oor_q <= w_addr_oor;
                if (READ_LAT == 1) begin
                    rdata_q <= w_live_word;
                    cnt_q   <= '0;
                    state_q <= RD_DRIVE;
                end else begin
                    cnt_q   <= c_LAT_M1;
                    state_q <= RD_WAIT;
                end
            end else if (state_q == RD_WAIT) begin
                // The sampling edge counts as the first latency edge.
                if (cnt_q <= c_CNT_W'(1)) begin
                    rdata_q <= w_cap_word;
                    cnt_q   <= '0;
                    state_q <= RD_DRIVE;
                end else begin
                    cnt_q <= cnt_q - c_CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            if (w_wr_req && !w_addr_oor) begin
                if (!UB)
                    mem_q[ADDR[ADDR_W-1:0]][15:8] <= Data[15:8];
                if (!LB)
                    mem_q[ADDR[ADDR_W-1:0]][7:0] <= Data[7:0];
            end else if (load_valid && load_ready) begin
                mem_q[load_addr] <= load_data;
            end
        end
    end

    assign load_ready = Reset && (state_q == IDLE) && CE;
    assign oor_err    = oor_q;
    assign Data       = ((state_q == RD_DRIVE) && w_rd_req) ? rdata_q : 16'hzzzz;

endmodule
`default_nettype wire

// File: tb/tb_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_responder
// Brief    : Scoreboard bench for sram_responder (ADDR_W=10, READ_LAT=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_responder;

    localparam int          ADDR_W = 10;
    localparam logic [15:0] c_REL  = 16'hFFFF;   // released bus value (pulled up)

    logic              Clk, Reset, CE, UB, LB, OE, WE;
    logic [19:0]       ADDR;
    wire  [15:0]       Data;
    logic              load_valid;
    logic              load_ready;
    logic [ADDR_W-1:0] load_addr;
    logic [15:0]       load_data;
    logic              oor_err;
    logic              tb_en;
    logic [15:0]       tb_drive;

    logic [15:0] exp_q[$];
    logic [15:0] got;
    int          checks = 0;
    int          errors = 0;

    for (genvar i = 0; i < 16; i++) begin : g_pull
        pullup (Data[i]);
    end
    assign Data = tb_en ? tb_drive : 16'hzzzz;

    sram_responder #(.ADDR_W(ADDR_W), .READ_LAT(2)) dut (
        .Clk(Clk), .Reset(Reset), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE),
        .ADDR(ADDR), .Data(Data), .load_valid(load_valid), .load_ready(load_ready),
        .load_addr(load_addr), .load_data(load_data), .oor_err(oor_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic bus_release();
        CE = 1'b1; OE = 1'b1; WE = 1'b1; UB = 1'b1; LB = 1'b1; tb_en = 1'b0;
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [15:0] d);
        load_valid = 1'b1; load_addr = a; load_data = d;
        #1;
        checks++;
        if (load_ready !== 1'b1) begin
            errors++;
            $display("FAIL preload_ready addr=%0h got=%b want=1", a, load_ready);
        end
        tick();
        load_valid = 1'b0;
    endtask

    task automatic bus_write(input logic [19:0] a, input logic [15:0] d,
                             input logic ub, input logic lb);
        CE = 1'b0; OE = 1'b1; WE = 1'b0; UB = ub; LB = lb; ADDR = a;
        tb_en = 1'b1; tb_drive = d;
        tick();
        bus_release();
        tick();
    endtask

    // Read with exact latency: released after the sampling edge, driven after the next.
    task automatic bus_read(input logic [19:0] a, input logic [15:0] exp, input string nm);
        CE = 1'b0; OE = 1'b0; WE = 1'b1; ADDR = a; tb_en = 1'b0;
        exp_q.push_back(exp);
        tick();
        checks++;
        if (Data !== c_REL) begin
            errors++;
            $display("FAIL %s_wait got=%h want=released(%h)", nm, Data, c_REL);
        end
        tick();
        got = exp_q.pop_front();
        checks++;
        if (Data !== got) begin
            errors++;
            $display("FAIL %s_data got=%h want=%h", nm, Data, got);
        end
        bus_release();
        tick();
    endtask

    task automatic test_reset();
        Reset = 1'b0; bus_release(); ADDR = '0; load_valid = 1'b0;
        load_addr = '0; load_data = '0; tb_drive = '0;
        tick(); tick();
        checks++;
        if (load_ready !== 1'b0) begin errors++; $display("FAIL reset_load_ready got=%b want=0", load_ready); end
        checks++;
        if (oor_err !== 1'b0) begin errors++; $display("FAIL reset_oor got=%b want=0", oor_err); end
        checks++;
        if (Data !== c_REL) begin errors++; $display("FAIL reset_data got=%h want=%h", Data, c_REL); end
        Reset = 1'b1;
        tick();
        checks++;
        if (load_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got=%b want=1", load_ready); end
    endtask

    task automatic test_preload();
        preload(10'h005, 16'hBEEF);
        preload(10'h003, 16'h1234);
        preload(10'h001, 16'h1111);
        preload(10'h002, 16'h2222);
        preload(10'h000, 16'h0A0A);
        preload(10'h00A, 16'h3C3C);
        bus_read(20'h00005, 16'hBEEF, "preload_rd5");
    endtask

    task automatic test_byte_write();
        bus_write(20'h00003, 16'hABCD, 1'b0, 1'b1);
        bus_read(20'h00003, 16'hAB34, "upper_lane");
        bus_write(20'h00003, 16'h0099, 1'b1, 1'b0);
        bus_read(20'h00003, 16'hAB99, "lower_lane");
        bus_write(20'h00003, 16'h1357, 1'b1, 1'b1);
        bus_read(20'h00003, 16'hAB99, "no_lane");
    endtask

    task automatic test_write_priority();
        CE = 1'b0; OE = 1'b0; WE = 1'b0; UB = 1'b0; LB = 1'b0; ADDR = 20'h00007; tb_en = 1'b0;
        #1;
        checks++;
        if (Data !== c_REL) begin errors++; $display("FAIL wr_prio_drive got=%h want=%h", Data, c_REL); end
        tb_en = 1'b1; tb_drive = 16'h5555;
        tick();
        bus_release();
        tick();
        bus_read(20'h00007, 16'h5555, "wr_prio_rd7");
        // Turn a live read drive into a write: the drive must release at once.
        CE = 1'b0; OE = 1'b0; WE = 1'b1; ADDR = 20'h00005;
        tick(); tick();
        checks++;
        if (Data !== 16'hBEEF) begin errors++; $display("FAIL drive_before_we got=%h want=BEEF", Data); end
        WE = 1'b0; UB = 1'b0; LB = 1'b0;
        #1;
        checks++;
        if (Data !== c_REL) begin errors++; $display("FAIL drive_we_gate got=%h want=%h", Data, c_REL); end
        tb_en = 1'b1; tb_drive = 16'h2468;
        tick();
        bus_release();
        tick();
        bus_read(20'h00005, 16'h2468, "write_from_drive");
    endtask

    task automatic test_addr_change();
        CE = 1'b0; OE = 1'b0; WE = 1'b1; ADDR = 20'h00001;
        exp_q.push_back(16'h1111);
        tick(); tick();
        got = exp_q.pop_front();
        checks++;
        if (Data !== got) begin errors++; $display("FAIL ac_first got=%h want=%h", Data, got); end
        ADDR = 20'h00002;
        exp_q.push_back(16'h2222);
        tick();
        checks++;
        if (Data !== c_REL) begin errors++; $display("FAIL ac_restart got=%h want=%h", Data, c_REL); end
        tick();
        got = exp_q.pop_front();
        checks++;
        if (Data !== got) begin errors++; $display("FAIL ac_second got=%h want=%h", Data, got); end
        OE = 1'b1;
        #1;
        checks++;
        if (Data !== c_REL) begin errors++; $display("FAIL ac_oe_release got=%h want=%h", Data, c_REL); end
        bus_release();
        tick();
    endtask

    task automatic test_oor();
        checks++;
        if (oor_err !== 1'b0) begin errors++; $display("FAIL oor_before got=%b want=0", oor_err); end
        bus_write(20'h00400, 16'h7777, 1'b0, 1'b0);
        checks++;
        if (oor_err !== 1'b1) begin errors++; $display("FAIL oor_after_wr got=%b want=1", oor_err); end
        bus_read(20'h00400, 16'h0000, "oor_read");
        bus_read(20'h00000, 16'h0A0A, "oor_alias0");
        checks++;
        if (oor_err !== 1'b1) begin errors++; $display("FAIL oor_sticky got=%b want=1", oor_err); end
    endtask

    task automatic test_contention_reset();
        CE = 1'b0; load_valid = 1'b1; load_addr = 10'h00A; load_data = 16'h9999;
        #1;
        checks++;
        if (load_ready !== 1'b0) begin errors++; $display("FAIL cont_ready got=%b want=0", load_ready); end
        tick();
        load_valid = 1'b0;
        bus_release();
        tick();
        bus_read(20'h0000A, 16'h3C3C, "cont_no_write");
        CE = 1'b0; load_valid = 1'b1; load_addr = 10'h009; load_data = 16'h4242;
        tick();
        CE = 1'b1;
        #1;
        checks++;
        if (load_ready !== 1'b1) begin errors++; $display("FAIL cont_release got=%b want=1", load_ready); end
        tick();
        load_valid = 1'b0;
        bus_read(20'h00009, 16'h4242, "cont_held_load");
        // Abandon a read in RD_WAIT with reset; nothing is expected from it.
        CE = 1'b0; OE = 1'b0; WE = 1'b1; ADDR = 20'h00009;
        tick();
        Reset = 1'b0;
        tick();
        checks++;
        if (Data !== c_REL) begin errors++; $display("FAIL rst_mid_data got=%h want=%h", Data, c_REL); end
        checks++;
        if (oor_err !== 1'b0) begin errors++; $display("FAIL rst_mid_oor got=%b want=0", oor_err); end
        tick();
        checks++;
        if (Data !== c_REL) begin errors++; $display("FAIL rst_hold_data got=%h want=%h", Data, c_REL); end
        Reset = 1'b1;
        bus_release();
        tick();
        bus_read(20'h00009, 16'h4242, "array_kept");
    endtask

    initial begin
        test_reset();
        test_preload();
        test_byte_write();
        test_write_priority();
        test_addr_change();
        test_oor();
        test_contention_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
